multi_word_serial_adder: RTL and testbench
==========================================

Name: multi_word_serial_adder

Overview:
Sequential, parametrised successor to the single-cycle edge-muxed adder tile. Accepts multi-precision operands of NWORDS*WIDTH bits over a narrow WIDTH-bit input bus, one word per beat, LSW first, interleaved A then B. Adds or subtracts the operands word by word through one WIDTH-bit carry-look-ahead slice, chaining the carry in a register. Streams sum words out and reports the final carry and signed overflow. Sits behind the TT io_in/io_out pin wrapper, so operands wider than the pin budget can be processed.

Parameters:
WIDTH, 7, word width of the data path and of the I/O buses (>=2)
NWORDS, 2, words per operand (>=1); operand width = NWORDS*WIDTH

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  begin operation; sampled only in IDLE
sub  input  1  mode, latched with start: 0 = A+B, 1 = A-B
in_valid  input  1  in_data carries a word this cycle
in_data  input  WIDTH  operand word
busy  output  1  high from the cycle after start is accepted until DONE exits
out_valid  output  1  one-cycle pulse; out_data holds a sum word
out_data  output  WIDTH  sum word, LSW first
done  output  1  one-cycle pulse at end of operation
carry_out  output  1  final carry; for sub, 1 = no borrow; held until next start
overflow  output  1  signed overflow of the full result; held until next start

Behaviour:
- Clock and reset: single clock clk; rst_n is asynchronous and active-low.
- Reset values: state=IDLE, word_idx=0, carry_reg=0, sub_reg=0, a_reg=0, busy=0, out_valid=0, out_data=0, done=0, carry_out=0, overflow=0.
- Reset asserted mid-operation aborts immediately. No partial output pulses follow.
- States: IDLE, LOAD_A, LOAD_B, DONE.
  - IDLE: on start=1, latch sub_reg=sub, set carry_reg=sub, word_idx=0, clear carry_out/overflow, go to LOAD_A. in_valid is ignored in IDLE.
  - LOAD_A: on in_valid, a_reg<=in_data, go to LOAD_B.
  - LOAD_B: on in_valid, compute {c,s} = a_reg + (in_data XOR {WIDTH{sub_reg}}) + carry_reg.
    - Next edge: out_data<=s, out_valid<=1, carry_reg<=c.
    - If word_idx==NWORDS-1: carry_out<=c, overflow<=(a_msb==b'_msb)&&(s_msb!=a_msb), where b' is the inverted-if-sub word; go to DONE.
    - Otherwise word_idx++ and go to LOAD_A.
  - DONE: done=1 for exactly one cycle, then IDLE.
- Beats: in_valid low stalls the FSM; gaps of any length are allowed. There is no backpressure on outputs.
- Latency: out_valid is asserted the cycle after each accepted B word. The final out_valid and done are asserted in the same cycle (registered together on the DONE entry edge).
- start while busy is ignored. busy=0 in IDLE only.
- Arithmetic: two's complement, modulo 2^(NWORDS*WIDTH). word_idx width = clog2(NWORDS), minimum 1; it wraps only via the reset to 0 on start.
- Adder slice is purely combinational. All outputs are registered.

Decomposition:
- Shared package/header: state encoding localparams (ST_IDLE, ST_LOAD_A, ST_LOAD_B, ST_DONE) and the default WIDTH/NWORDS constants, alongside the existing bit-id defines.
- One sub-module: the existing carry_look_ahead (ports a, b, y=carry-in, c, s), instantiated with WIDTH=WIDTH. The FSM, operand registers and carry chaining live in multi_word_serial_adder.

Test Plan:
- Add with carry chaining (WIDTH=7, NWORDS=2): A=0x3FFF (words 0x7F,0x7F), B=0x0001 (words 0x01,0x00), sub=0 -> out words 0x00,0x00; carry_out=1; overflow=0; done pulses with the 2nd out_valid.
- Subtract with borrow: A=5 (0x05,0x00), B=7 (0x07,0x00), sub=1 -> out 0x7E,0x7F; carry_out=0; overflow=0.
- Signed overflow: A=0x1FFF (0x7F,0x3F), B=1 (0x01,0x00), sub=0 -> out 0x00,0x40; carry_out=0; overflow=1.
- Stalls and ignored inputs:
  - in_valid pulses with 3-cycle gaps -> same results as back-to-back input.
  - in_valid while IDLE -> no state change.
  - start asserted during LOAD_B -> ignored; the operation completes unchanged.
- Reset mid-operation: assert rst_n=0 asynchronously after the first B word -> busy, out_valid, done, carry_out and overflow drop to 0 without waiting for a clock edge. A subsequent fresh operation (A=2, B=3) -> out 0x05,0x00.
- Parameter sweep: WIDTH=4, NWORDS=4, 256 random A/B pairs in both modes -> concatenated out words, carry_out and overflow match the reference model.

Source files
------------

// File: rtl/multi_word_serial_adder_pkg.sv
// Shared definitions for the multi-word serial adder: FSM encoding, default
// geometry and a helper for sizing the word index.
package multi_word_serial_adder_pkg;

  localparam int DEFAULT_WIDTH  = 7;
  localparam int DEFAULT_NWORDS = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD_A = 2'd1,
    ST_LOAD_B = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // A single-word operand still needs a 1-bit index register.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/multi_word_serial_adder_cla.sv
// One WIDTH-bit carry-look-ahead slice: s = a + b + y, carry out on c.
// Purely combinational; the caller chains the carry through a register.
module carry_look_ahead
  import multi_word_serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             y,
  output logic             c,
  output logic [WIDTH-1:0] s
);

  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [WIDTH:0]   cc;

  assign cc[0] = y;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign g[gi]      = a[gi] & b[gi];
      assign p[gi]      = a[gi] ^ b[gi];
      assign cc[gi + 1] = g[gi] | (p[gi] & cc[gi]);
      assign s[gi]      = p[gi] ^ cc[gi];
    end
  endgenerate

  assign c = cc[WIDTH];

endmodule

// File: rtl/multi_word_serial_adder.sv
// Multi-precision add/subtract over a narrow bus: A and B words arrive
// interleaved LSW first, each B word produces one registered sum word.
module multi_word_serial_adder
  import multi_word_serial_adder_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int NWORDS = DEFAULT_NWORDS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             busy,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             done,
  output logic             carry_out,
  output logic             overflow
);

  localparam int                IDXW     = idx_width(NWORDS);
  localparam logic [IDXW-1:0]   LAST_IDX = IDXW'(NWORDS - 1);

  state_t           state_reg, state_next;
  logic [IDXW-1:0]  word_idx_reg;
  logic             carry_reg;
  logic             sub_reg;
  logic [WIDTH-1:0] a_reg;
  logic             busy_reg;
  logic             out_valid_reg;
  logic [WIDTH-1:0] out_data_reg;
  logic             done_reg;
  logic             carry_out_reg;
  logic             overflow_reg;

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] sum;
  logic             sum_c;
  logic             accept_start;
  logic             accept_a;
  logic             accept_b;
  logic             last_word;

  // Subtraction is A + ~B + 1; the +1 enters through the initial carry.
  assign b_eff     = in_data ^ {WIDTH{sub_reg}};
  assign last_word = (word_idx_reg == LAST_IDX);

  carry_look_ahead #(.WIDTH(WIDTH)) u_cla (
    .a (a_reg),
    .b (b_eff),
    .y (carry_reg),
    .c (sum_c),
    .s (sum)
  );

  always_comb begin
    state_next   = state_reg;
    accept_start = 1'b0;
    accept_a     = 1'b0;
    accept_b     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          accept_start = 1'b1;
          state_next   = ST_LOAD_A;
        end
      end
      ST_LOAD_A: begin
        if (in_valid) begin
          accept_a   = 1'b1;
          state_next = ST_LOAD_B;
        end
      end
      ST_LOAD_B: begin
        if (in_valid) begin
          accept_b   = 1'b1;
          state_next = last_word ? ST_DONE : ST_LOAD_A;
        end
      end
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_idx_reg  <= '0;
      carry_reg     <= 1'b0;
      sub_reg       <= 1'b0;
      a_reg         <= '0;
      busy_reg      <= 1'b0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      done_reg      <= 1'b0;
      carry_out_reg <= 1'b0;
      overflow_reg  <= 1'b0;
    end else begin
      busy_reg      <= (state_next != ST_IDLE);
      out_valid_reg <= accept_b;
      done_reg      <= accept_b && last_word;
      if (accept_start) begin
        sub_reg       <= sub;
        carry_reg     <= sub;
        word_idx_reg  <= '0;
        carry_out_reg <= 1'b0;
        overflow_reg  <= 1'b0;
      end
      if (accept_a) a_reg <= in_data;
      if (accept_b) begin
        out_data_reg <= sum;
        carry_reg    <= sum_c;
        if (last_word) begin
          carry_out_reg <= sum_c;
          // Signed overflow is judged on the top word only, with B already inverted for subtract.
          overflow_reg  <= (a_reg[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a_reg[WIDTH-1]);
        end else begin
          word_idx_reg <= word_idx_reg + 1'b1;
        end
      end
    end
  end

  assign busy      = busy_reg;
  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign done      = done_reg;
  assign carry_out = carry_out_reg;
  assign overflow  = overflow_reg;

endmodule

// File: tb/tb_multi_word_serial_adder.sv
// Bench for the multi-word serial adder: directed cases on a 7x2 instance,
// randomized add/sub sweep on a 4x4 instance, checked against integer arithmetic.
module tb_multi_word_serial_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       sel = 1'b0;
  logic       start_s = 1'b0;
  logic       sub_s = 1'b0;
  logic       in_valid_s = 1'b0;
  logic [6:0] in_data_s = '0;

  logic       busy7, out_valid7, done7, carry_out7, overflow7;
  logic [6:0] out_data7;
  logic       busy4, out_valid4, done4, carry_out4, overflow4;
  logic [3:0] out_data4;

  multi_word_serial_adder #(.WIDTH(7), .NWORDS(2)) dut7 (
    .clk(clk), .rst_n(rst_n), .start(start_s && !sel), .sub(sub_s),
    .in_valid(in_valid_s && !sel), .in_data(in_data_s),
    .busy(busy7), .out_valid(out_valid7), .out_data(out_data7),
    .done(done7), .carry_out(carry_out7), .overflow(overflow7)
  );

  multi_word_serial_adder #(.WIDTH(4), .NWORDS(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start_s && sel), .sub(sub_s),
    .in_valid(in_valid_s && sel), .in_data(in_data_s[3:0]),
    .busy(busy4), .out_valid(out_valid4), .out_data(out_data4),
    .done(done4), .carry_out(carry_out4), .overflow(overflow4)
  );

  logic       busy_m, out_valid_m, done_m, carry_out_m, overflow_m;
  logic [6:0] out_data_m;
  assign busy_m      = sel ? busy4      : busy7;
  assign out_valid_m = sel ? out_valid4 : out_valid7;
  assign done_m      = sel ? done4      : done7;
  assign carry_out_m = sel ? carry_out4 : carry_out7;
  assign overflow_m  = sel ? overflow4  : overflow7;
  assign out_data_m  = sel ? {3'b000, out_data4} : out_data7;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One complete operation; poke drives a (to-be-ignored) start during the A->B gap.
  task automatic run_op(input bit s4, input logic [63:0] a_in, input logic [63:0] b_in,
                        input bit sb, input int gap, input bit poke, input string tag);
    int w, n, nb;
    logic [63:0] wmask, mask, a, b, got, exp_r;
    bit exp_c, exp_v, sa, sbb, sr;
    w = s4 ? 4 : 7;
    n = s4 ? 4 : 2;
    nb = w * n;
    wmask = (64'd1 << w) - 1;
    mask  = (64'd1 << nb) - 1;
    a = a_in & mask;
    b = b_in & mask;
    got = '0;
    sel = s4;

    if (sb) begin
      exp_r = (a - b) & mask;
      exp_c = (a >= b);
    end else begin
      exp_r = (a + b) & mask;
      exp_c = ((a + b) >> nb) != 0;
    end
    sa  = a[nb-1];
    sbb = b[nb-1];
    sr  = exp_r[nb-1];
    exp_v = sb ? ((sa != sbb) && (sr != sa)) : ((sa == sbb) && (sr != sa));

    @(negedge clk);
    start_s = 1'b1;
    sub_s   = sb;
    @(negedge clk);
    start_s = 1'b0;
    sub_s   = 1'b0;
    check({tag, ".busy_start"}, busy_m, 1);

    for (int i = 0; i < n; i++) begin
      in_valid_s = 1'b1;
      in_data_s  = 7'((a >> (i * w)) & wmask);
      @(negedge clk);
      in_valid_s = 1'b0;
      for (int g = 0; g < gap; g++) begin
        if (poke) begin
          start_s = 1'b1;
          sub_s   = ~sb;
        end
        @(negedge clk);
        start_s = 1'b0;
        sub_s   = 1'b0;
      end
      in_valid_s = 1'b1;
      in_data_s  = 7'((b >> (i * w)) & wmask);
      @(negedge clk);
      in_valid_s = 1'b0;
      check({tag, ".out_valid"}, out_valid_m, 1);
      check({tag, ".done_with_last"}, done_m, (i == n - 1) ? 1 : 0);
      got = got | ((64'(out_data_m) & wmask) << (i * w));
      if (i != n - 1) begin
        for (int g = 0; g < gap; g++) begin
          @(negedge clk);
          check({tag, ".out_valid_pulse"}, out_valid_m, 0);
        end
      end
    end
    check({tag, ".result"}, got, exp_r);
    check({tag, ".carry_out"}, carry_out_m, exp_c);
    check({tag, ".overflow"}, overflow_m, exp_v);
    @(negedge clk);
    check({tag, ".done_cleared"}, done_m, 0);
    check({tag, ".busy_cleared"}, busy_m, 0);
    check({tag, ".carry_held"}, carry_out_m, exp_c);
    $display("op %s s4=%0d sub=%0d a=0x%0h b=0x%0h res=0x%0h c=%0d v=%0d",
             tag, s4, sb, a, b, got, carry_out_m, overflow_m);
  endtask

  initial begin
    logic [63:0] ra, rb;

    repeat (2) @(negedge clk);
    check("reset.busy", busy7, 0);
    check("reset.out_valid", out_valid7, 0);
    check("reset.out_data", out_data7, 0);
    check("reset.done", done7, 0);
    check("reset.carry_out", carry_out7, 0);
    check("reset.overflow", overflow7, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(1'b0, 64'h3FFF, 64'h0001, 1'b0, 0, 1'b0, "add_chain");
    run_op(1'b0, 64'd5, 64'd7, 1'b1, 0, 1'b0, "sub_borrow");
    run_op(1'b0, 64'h1FFF, 64'h0001, 1'b0, 0, 1'b0, "signed_ovf");
    run_op(1'b0, 64'h3FFF, 64'h0001, 1'b0, 3, 1'b0, "add_gaps");
    run_op(1'b0, 64'd5, 64'd7, 1'b1, 3, 1'b0, "sub_gaps");

    // Words offered while idle must not be consumed.
    sel = 1'b0;
    @(negedge clk);
    in_valid_s = 1'b1;
    in_data_s  = 7'h55;
    repeat (3) @(negedge clk);
    in_valid_s = 1'b0;
    check("idle_in_valid.busy", busy7, 0);
    check("idle_in_valid.out_valid", out_valid7, 0);
    run_op(1'b0, 64'h1234, 64'h0ABC, 1'b0, 0, 1'b0, "after_idle_valid");

    run_op(1'b0, 64'h2000, 64'h0001, 1'b1, 2, 1'b1, "start_in_load_b");

    // Asynchronous reset right after the first B word.
    sel = 1'b0;
    @(negedge clk);
    start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    in_valid_s = 1'b1;
    in_data_s  = 7'h11;
    @(negedge clk);
    in_data_s  = 7'h22;
    @(negedge clk);
    in_valid_s = 1'b0;
    check("midreset.out_valid_before", out_valid7, 1);
    #2 rst_n = 1'b0;
    #1;
    check("midreset.busy", busy7, 0);
    check("midreset.out_valid", out_valid7, 0);
    check("midreset.done", done7, 0);
    check("midreset.carry_out", carry_out7, 0);
    check("midreset.overflow", overflow7, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midreset.no_pulse", out_valid7, 0);
    run_op(1'b0, 64'd2, 64'd3, 1'b0, 0, 1'b0, "after_reset");

    for (int k = 0; k < 256; k++) begin
      ra = {32'd0, $urandom};
      rb = {32'd0, $urandom};
      if ($urandom_range(0, 7) == 0) ra = 64'hFFFF;
      if ($urandom_range(0, 7) == 0) rb = 64'h0;
      run_op(1'b1, ra, rb, 1'b0, $urandom_range(0, 1), 1'b0, "sweep_add");
      run_op(1'b1, ra, rb, 1'b1, $urandom_range(0, 1), 1'b0, "sweep_sub");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
